// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
//   dec_state_e : scan-code set 2 prefix decoder states
//   PS2_E0/F0   : extended and break prefix bytes
//   ps2_event_t : one decoded key event {ext, brk, code}
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StE0,
      StF0,
      StE0F0
   } dec_state_e;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver.
// Synchronises the PS/2 pins, samples data on each falling PS/2 clock edge,
// assembles 11-bit frames and checks start/parity/stop. A watchdog aborts a
// partial frame that stalls for TIMEOUT_CYC clk cycles.
//   clk, resetn       : system clock, synchronous active-low reset
//   ps2_clk, ps2_data : asynchronous PS/2 pins
//   byte_valid        : 1-cycle pulse, byte_data holds a good frame's byte
//   byte_data         : received data byte
//   byte_err          : 1-cycle pulse, bad start/parity/stop bit
//   timeout_err       : 1-cycle pulse, partial frame aborted by the watchdog
module ps2_rx_frame #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_err,
   output logic       timeout_err
);

   localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]     clk_sync_q;
   logic [2:0]     data_sync_q;
   logic [3:0]     bit_idx_q;
   logic [9:0]     shift_q;
   logic [WdW-1:0] wdog_q;
   logic           byte_valid_q;
   logic [7:0]     byte_data_q;
   logic           byte_err_q;
   logic           timeout_q;

   logic strobe;
   logic data_bit;
   logic frame_ok;

   // Falling edge seen between the 2nd and 3rd flop; data from the 2nd flop.
   assign strobe   = clk_sync_q[2] & ~clk_sync_q[1];
   assign data_bit = data_sync_q[1];

   // At the 11th strobe shift_q holds {parity, data[7:0], start}; data_bit is stop.
   assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & data_bit;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_sync_q   <= 3'b111;
         data_sync_q  <= 3'b111;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         wdog_q       <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_err_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q  <= {data_sync_q[1:0], ps2_data};
         byte_valid_q <= 1'b0;
         byte_err_q   <= 1'b0;
         timeout_q    <= 1'b0;
         if (strobe) begin
            wdog_q <= '0;
            if (bit_idx_q == 4'd10) begin
               bit_idx_q <= '0;
               if (frame_ok) begin
                  byte_valid_q <= 1'b1;
                  byte_data_q  <= shift_q[8:1];
               end else begin
                  byte_err_q <= 1'b1;
               end
            end else begin
               shift_q   <= {data_bit, shift_q[9:1]};
               bit_idx_q <= bit_idx_q + 4'd1;
            end
         end else if (bit_idx_q != 4'd0) begin
            if (wdog_q == WdW'(TIMEOUT_CYC)) begin
               bit_idx_q <= '0;
               wdog_q    <= '0;
               timeout_q <= 1'b1;
            end else begin
               wdog_q <= wdog_q + WdW'(1);
            end
         end
      end
   end

   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign byte_err    = byte_err_q;
   assign timeout_err = timeout_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller top level.
// Decodes scan-code set 2 E0/F0 prefixes into key events and queues them in a
// FIFO presented on a valid/ready interface.
//   clk, resetn                 : system clock, synchronous active-low reset
//   ps2_clk, ps2_data           : asynchronous PS/2 pins
//   ev_valid/ev_ready           : event handshake (pop on valid & ready)
//   ev_code, ev_break, ev_ext   : head event, all zero when empty
//   ev_count                    : number of queued events
//   overflow, clr_overflow      : sticky drop flag and its clear
//   frame_err                   : 1-cycle pulse on frame error or timeout
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   output logic                        ev_valid,
   input  logic                        ev_ready,
   output logic [7:0]                  ev_code,
   output logic                        ev_break,
   output logic                        ev_ext,
   output logic [$clog2(FIFO_DEPTH):0] ev_count,
   output logic                        overflow,
   input  logic                        clr_overflow,
   output logic                        frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_err;
   logic       timeout_err;

   ps2_rx_frame #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk         (clk),
      .resetn      (resetn),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_err    (byte_err),
      .timeout_err (timeout_err)
   );

   assign frame_err = byte_err | timeout_err;

   // ---------------- Prefix decoder ----------------
   dec_state_e state_q;
   logic       is_e0;
   logic       is_f0;
   logic       is_prefix;
   logic       push;
   ps2_event_t push_ev;

   assign is_e0 = (byte_data == PS2_E0);
   assign is_f0 = (byte_data == PS2_F0);

   always_comb begin
      is_prefix = 1'b0;
      unique case (state_q)
         StIdle:         is_prefix = is_e0 | is_f0;
         StE0:           is_prefix = is_f0;
         StF0, StE0F0:   is_prefix = is_e0;
         default:        is_prefix = 1'b0;
      endcase
   end

   // Event push is combinational so the FIFO write lands in the byte's cycle.
   always_comb begin
      push         = byte_valid & ~is_prefix;
      push_ev.ext  = (state_q == StE0) | (state_q == StE0F0);
      push_ev.brk  = (state_q == StF0) | (state_q == StE0F0);
      push_ev.code = byte_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else if (byte_err) begin
         state_q <= StIdle;
      end else if (byte_valid) begin
         unique case (state_q)
            StIdle:       state_q <= is_e0 ? StE0 : (is_f0 ? StF0 : StIdle);
            StE0:         state_q <= is_f0 ? StE0F0 : StIdle;
            StF0, StE0F0: state_q <= is_e0 ? StE0 : StIdle;
            default:      state_q <= StIdle;
         endcase
      end
   end

   // ---------------- Event FIFO ----------------
   ps2_event_t     mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_d;
   logic           overflow_q;
   logic           overflow_d;
   logic           empty;
   logic           full;
   logic           pop;
   logic           do_push;
   ps2_event_t     head;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign pop     = ~empty & ev_ready;
   // A pop frees the slot the simultaneous push needs.
   assign do_push = push & (~full | pop);

   always_comb begin
      count_d = count_q;
      if (do_push & ~pop) begin
         count_d = count_q + CW'(1);
      end else if (pop & ~do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // A new drop wins over a clear in the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (push & full & ~pop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset: the count masks stale entries.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_ev;
      end
   end

   assign head     = empty ? '0 : mem_q[rd_ptr_q];
   assign ev_valid = ~empty;
   assign ev_code  = head.code;
   assign ev_break = head.brk;
   assign ev_ext   = head.ext;
   assign ev_count = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: table of PS/2 bytes with expected
// events, plus hand sequences for latency, timeout, reset, overflow and
// full-FIFO push/pop.
module tb_ps2_kbd_ctrl;

   localparam int unsigned Depth   = 8;
   localparam int unsigned Timeout = 300;
   localparam int          Half    = 8;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_break;
   logic       ev_ext;
   logic [3:0] ev_count;
   logic       overflow;
   logic       clr_overflow = 1'b0;
   logic       frame_err;

   int tests = 0;
   int fails = 0;
   int err_cnt = 0;

   ps2_kbd_ctrl #(
      .FIFO_DEPTH  (Depth),
      .TIMEOUT_CYC (Timeout)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_code      (ev_code),
      .ev_break     (ev_break),
      .ev_ext       (ev_ext),
      .ev_count     (ev_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   // Counts every cycle frame_err is high, so a stretched pulse shows up as >1.
   always @(posedge clk) begin
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   typedef struct {
      logic [7:0] data;
      logic       bad_par;
      int         exp_err;
      logic       exp_ev;
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic bad);
      return {1'b1, (~^d) ^ bad, d, 1'b0};
   endfunction

   // Drives n bits; optionally leaves ps2_clk low after the last falling edge.
   task automatic send_bits(input logic [10:0] bits, input int n, input bit leave_low);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (Half) @(negedge clk);
         ps2_clk = 1'b0;
         if (!(leave_low && i == n - 1)) begin
            repeat (Half) @(negedge clk);
            ps2_clk = 1'b1;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad);
      send_bits(frame(d, bad), 11, 1'b0);
      repeat (6) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   task automatic expect_head(input string name, input logic [7:0] code, input logic brk,
                              input logic ext);
      check({name, ".valid"}, 32'(ev_valid), 32'd1);
      check({name, ".code"},  32'(ev_code),  32'(code));
      check({name, ".brk"},   32'(ev_break), 32'(brk));
      check({name, ".ext"},   32'(ev_ext),   32'(ext));
   endtask

   initial begin
      int e0;

      vecs[0]  = '{8'h1C, 1'b0, 0, 1'b1, 8'h1C, 1'b0, 1'b0};
      vecs[1]  = '{8'hE0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{8'hF0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{8'h75, 1'b0, 0, 1'b1, 8'h75, 1'b1, 1'b1};
      vecs[4]  = '{8'hF0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5]  = '{8'h1C, 1'b0, 0, 1'b1, 8'h1C, 1'b1, 1'b0};
      vecs[6]  = '{8'hE0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[7]  = '{8'h6B, 1'b0, 0, 1'b1, 8'h6B, 1'b0, 1'b1};
      vecs[8]  = '{8'h1C, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[9]  = '{8'h1B, 1'b0, 0, 1'b1, 8'h1B, 1'b0, 1'b0};
      vecs[10] = '{8'hE0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[11] = '{8'h5A, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[12] = '{8'h74, 1'b0, 0, 1'b1, 8'h74, 1'b0, 1'b0};
      vecs[13] = '{8'hF0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[14] = '{8'hE0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[15] = '{8'h70, 1'b0, 0, 1'b1, 8'h70, 1'b0, 1'b1};

      // Reset state
      repeat (4) @(negedge clk);
      check("rst.valid",     32'(ev_valid),  32'd0);
      check("rst.code",      32'(ev_code),   32'd0);
      check("rst.brk",       32'(ev_break),  32'd0);
      check("rst.ext",       32'(ev_ext),    32'd0);
      check("rst.count",     32'(ev_count),  32'd0);
      check("rst.overflow",  32'(overflow),  32'd0);
      check("rst.frame_err", 32'(frame_err), 32'd0);
      resetn = 1'b1;
      repeat (4) @(negedge clk);

      // Latency: pin falls, flop1 at edge 1, strobe after edge 2 (N),
      // byte to decoder N+1, FIFO write at edge 4, valid from N+2.
      send_bits(frame(8'h1C, 1'b0), 11, 1'b1);
      repeat (3) @(negedge clk);
      check("lat.valid_early", 32'(ev_valid), 32'd0);
      check("lat.count_early", 32'(ev_count), 32'd0);
      @(negedge clk);
      check("lat.valid", 32'(ev_valid), 32'd1);
      check("lat.count", 32'(ev_count), 32'd1);
      expect_head("lat", 8'h1C, 1'b0, 1'b0);
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
      pop_one();
      check("lat.empty", 32'(ev_valid), 32'd0);

      // Table-driven bytes
      for (int i = 0; i < 16; i++) begin
         e0 = err_cnt;
         send_frame(vecs[i].data, vecs[i].bad_par);
         check($sformatf("vec%0d.err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d.valid", i), 32'(ev_valid), 32'(vecs[i].exp_ev));
         if (vecs[i].exp_ev) begin
            expect_head($sformatf("vec%0d", i), vecs[i].code, vecs[i].brk, vecs[i].ext);
            pop_one();
            check($sformatf("vec%0d.popped", i), 32'(ev_count), 32'd0);
         end
      end

      // Timeout: 5 bits then idle past the watchdog limit
      e0 = err_cnt;
      send_bits(frame(8'h33, 1'b0), 5, 1'b0);
      repeat (Timeout / 2) @(negedge clk);
      check("to.no_early_err", 32'(err_cnt - e0), 32'd0);
      repeat (Timeout) @(negedge clk);
      check("to.err", 32'(err_cnt - e0), 32'd1);
      check("to.valid", 32'(ev_valid), 32'd0);
      send_frame(8'h23, 1'b0);
      check("to.err_after", 32'(err_cnt - e0), 32'd1);
      expect_head("to.next", 8'h23, 1'b0, 1'b0);

      // Reset mid-frame with an event queued
      send_bits(frame(8'h44, 1'b0), 4, 1'b0);
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rstmid.count", 32'(ev_count), 32'd0);
      check("rstmid.valid", 32'(ev_valid), 32'd0);
      send_frame(8'h2A, 1'b0);
      check("rstmid.count1", 32'(ev_count), 32'd1);
      expect_head("rstmid.next", 8'h2A, 1'b0, 1'b0);
      pop_one();

      // Overflow: 9 makes into an 8-deep FIFO
      for (int k = 0; k < 9; k++) send_frame(8'h10 + 8'(k), 1'b0);
      check("ovf.count", 32'(ev_count), 32'd8);
      check("ovf.flag", 32'(overflow), 32'd1);
      expect_head("ovf.head", 8'h10, 1'b0, 1'b0);
      @(negedge clk);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      check("ovf.cleared", 32'(overflow), 32'd0);

      // Full FIFO: pop in the same cycle as the push of 0x30
      send_bits(frame(8'h30, 1'b0), 11, 1'b1);
      repeat (3) @(negedge clk);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      check("fpp.count", 32'(ev_count), 32'd8);
      check("fpp.overflow", 32'(overflow), 32'd0);
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expect_head($sformatf("drain%0d", k), (k < 7) ? 8'h11 + 8'(k) : 8'h30, 1'b0, 1'b0);
         pop_one();
      end
      check("drain.count", 32'(ev_count), 32'd0);
      check("drain.valid", 32'(ev_valid), 32'd0);
      check("drain.code",  32'(ev_code),  32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

PS/2 keyboard controller sitting between the raw `ps2_clk`/`ps2_data` pins and the CPU-side peripheral bus glue. It receives 11-bit device-to-host frames and decodes scan-code set 2 prefix sequences (E0 extended, F0 break) into single key events. Events are buffered in a small FIFO and presented on a valid/ready interface, with overflow and frame-error reporting. A watchdog aborts stalled partial frames.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, ≥2.
- `TIMEOUT_CYC`, 50000: idle `clk` cycles mid-frame before the frame is aborted.
- `clk` in 1: system clock.
- `resetn` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: asynchronous PS/2 clock pin.
- `ps2_data` in 1: asynchronous PS/2 data pin.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out 8: scan code of the head event, with prefixes stripped.
- `ev_break` out 1: 1 = key release (F0 seen).
- `ev_ext` out 1: 1 = extended key (E0 seen).
- `ev_count` out clog2(FIFO_DEPTH)+1: number of events held.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `clr_overflow` in 1: clears `overflow`.
- `frame_err` out 1: 1-cycle pulse on a bad start/parity/stop bit or a timeout.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through a 3-flop synchroniser. A sample strobe fires when the synchronised clock goes from 1 to 0. Data is taken from the same synchroniser stage as the edge.
- **Frame capture:** bit index 0..10. The bits are start (must be 0), 8 data bits LSB first, odd parity over data+parity, and stop (must be 1).
  - On the 11th strobe, check all three conditions.
  - If all pass, emit the byte to the decoder.
  - If any fails, drop the byte, pulse `frame_err`, and force the decoder to IDLE.
  - In both cases the bit index returns to 0.
- **Watchdog:** while the bit index ≠ 0, count `clk` cycles since the last strobe. A strobe resets the count. On reaching `TIMEOUT_CYC`, set the bit index to 0 and pulse `frame_err`. Decoder state is unchanged.
- **Decoder FSM** (states IDLE, E0, F0, E0F0):
  - IDLE: byte E0 → E0; byte F0 → F0.
  - E0: byte F0 → E0F0.
  - F0 or E0F0: byte E0 → E0 (resync).
  - Any other byte in any state: push event {ext = state∈{E0,E0F0}, break = state∈{F0,E0F0}, code}, then → IDLE.
  - Device replies (AA, FA, FE, EE, 00, FF) are pushed as ordinary events.
- **FIFO:**
  - Push on decoder emit; pop when `ev_valid & ev_ready`.
  - Push while full and no pop: drop the new event and set `overflow`.
  - Push and pop in the same cycle while full: both take effect and the count is unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `ev_code`, `ev_break` and `ev_ext` read 0 when the FIFO is empty.
- **Overflow flag:** `clr_overflow` and a new overflow in the same cycle → `overflow` stays 1.

## Timing
- **Reset values:** `ev_valid`=0, `ev_code`=0, `ev_break`=0, `ev_ext`=0, `ev_count`=0, `overflow`=0, `frame_err`=0. Reset also sets bit index 0, watchdog 0 and FSM IDLE, and clears the synchronisers to 1.
- **Reset mid-frame:** discards the partial frame and all FIFO contents.
- **Latency:** with the 11th strobe in cycle N, the byte reaches the decoder in N+1. For an emitting byte, the FIFO write is in N+1 and `ev_valid`=1 from N+2. Prefix bytes produce no event.
- **`frame_err` pulse:** cycle N+1 for a frame error; the cycle after the count hits `TIMEOUT_CYC` for a timeout.
- **Pop timing:** on a pop in cycle M, the next head (or `ev_valid`=0) appears in M+1. `ev_count` updates in the cycle after a push or pop.
- **Handshake stability:** `ev_*` are stable while `ev_valid & !ev_ready`.

## Structure
- **Package `ps2_pkg`:** decoder state enum, constants `PS2_E0`=8'hE0 and `PS2_F0`=8'hF0, and a 10-bit packed event struct {ext, brk, code[7:0]}.
- **Sub-module `ps2_rx_frame`:** synchronisers, edge detect, bit capture, checks and watchdog. Outputs `byte_valid`, `byte_data`, `byte_err`.
- **Top level:** decoder FSM, FIFO, overflow logic.

## Test plan
- **Clean make:** frame 0x1C with correct parity → one event {code 1C, break 0, ext 0}, `ev_valid` high at N+2.
- **Extended break:** E0, F0, 0x75 → one event {code 75, break 1, ext 1}; no events for the prefixes.
- **Bad parity:** 0x1C with even parity, then 0x1B valid → `frame_err` pulse once; only {1B, 0, 0} is queued.
- **Timeout:** send 5 bits then idle > `TIMEOUT_CYC` → `frame_err` pulse; the next full frame 0x23 is decoded correctly.
- **Overflow:** `ev_ready`=0, send 9 makes with `FIFO_DEPTH`=8 → `ev_count`=8, `overflow`=1, and the 9th code is absent.
  - Then pulse `clr_overflow` → `overflow`=0.
- **Full-FIFO push/pop:** push while full with `ev_ready`=1 in the same cycle → count stays 8 and the pushed event lands at the tail.
